// File: rtl/i2c_dma_fifo.sv
// Byte FIFO for the I2C datapath with a burst-request DMA engine on one side.
// DIR = 0: DMA writes and the shifter reads (TX). DIR = 1: shifter writes and DMA reads (RX).
module i2c_dma_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter bit          DIR        = 1'b0,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                  i2c_core_clk,
  input  logic                  i2c_rst,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [AW:0]           level_o,
  input  logic                  flush_i,
  input  logic                  dma_en_i,
  input  logic [AW:0]           burst_i,
  input  logic [15:0]           xfer_len_i,
  output logic                  dma_req_o,
  output logic                  dma_lreq_o,
  input  logic                  dma_clr_i,
  input  logic                  dma_tc_i,
  output logic                  done_o,
  output logic                  ovf_o,
  output logic                  udf_o,
  input  logic                  err_clr_i
);

  localparam logic [AW:0] LvlFull = DEPTH[AW:0];

  typedef enum logic [2:0] {StIdle, StArm, StReq, StHold, StDone} state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           level_q, level_d;
  logic                  full_q, empty_q, ovf_q, udf_q;
  logic                  push_ok, pop_ok, ovf_set, udf_set;

  state_e                state_q, state_d;
  logic [15:0]           remain_q, remain_d;
  logic                  req_q, lreq_q, done_q, done_d;
  logic                  dma_beat, req_cond, in_req, last;

  // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
  always_comb begin
    push_ok = wr_en_i && !flush_i && ((level_q != LvlFull) || rd_en_i);
    pop_ok  = rd_en_i && !flush_i && (level_q != '0);
    ovf_set = wr_en_i && !flush_i && (level_q == LvlFull) && !rd_en_i;
    udf_set = rd_en_i && !flush_i && (level_q == '0);
    level_d = level_q;
    if (flush_i) begin
      level_d = '0;
    end else if (push_ok && !pop_ok) begin
      level_d = level_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge i2c_core_clk) begin
    if (i2c_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q <= level_d;
      full_q  <= (level_d == LvlFull);
      empty_q <= (level_d == '0);
      if (ovf_set)        ovf_q <= 1'b1;
      else if (err_clr_i) ovf_q <= 1'b0;
      if (udf_set)        udf_q <= 1'b1;
      else if (err_clr_i) udf_q <= 1'b0;
    end
  end

  always_comb begin
    dma_beat = DIR ? pop_ok : push_ok;
    if (DIR) begin
      req_cond = (level_q >= burst_i) || ((remain_q != '0) && (16'(level_q) >= remain_q));
    end else begin
      req_cond = (LvlFull - level_q) >= burst_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    if (dma_beat && (remain_q != '0)) remain_d = remain_q - 16'd1;
    unique case (state_q)
      StIdle: begin
        if (dma_en_i) begin
          remain_d = xfer_len_i;
          if (xfer_len_i == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StArm;
          end
        end
      end
      StArm: if (req_cond) state_d = StReq;
      StReq: begin
        if (dma_tc_i) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else if (dma_clr_i) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (remain_q == '0) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          state_d = StArm;
        end
      end
      StDone: state_d = StDone;
      default: state_d = StIdle;
    endcase
    if (!dma_en_i) begin
      state_d = StIdle;
      done_d  = 1'b0;
    end
    // Request stays up only while REQ persists, so it drops on the clr/tc edge.
    in_req = (state_q == StReq) && (state_d == StReq);
    last   = remain_d <= 16'(burst_i);
  end

  always_ff @(posedge i2c_core_clk) begin
    if (i2c_rst) begin
      state_q  <= StIdle;
      remain_q <= '0;
      req_q    <= 1'b0;
      lreq_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      req_q    <= in_req && !last;
      lreq_q   <= in_req && last;
      done_q   <= done_d;
    end
  end

  assign rd_data_o  = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign level_o    = level_q;
  assign ovf_o      = ovf_q;
  assign udf_o      = udf_q;
  assign dma_req_o  = req_q;
  assign dma_lreq_o = lreq_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_i2c_dma_fifo.sv
// Directed bench: one TX and one RX instance, DEPTH = 16, hand-computed expectations.
module tb_i2c_dma_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // TX instance signals
  logic       t_wr, t_rd, t_flush, t_en, t_clr, t_tc, t_errclr;
  logic [7:0] t_wdata, t_rdata;
  logic [4:0] t_burst, t_level;
  logic [15:0] t_len;
  logic       t_full, t_empty, t_req, t_lreq, t_done, t_ovf, t_udf;

  // RX instance signals
  logic       r_wr, r_rd, r_flush, r_en, r_clr, r_tc, r_errclr;
  logic [7:0] r_wdata, r_rdata;
  logic [4:0] r_burst, r_level;
  logic [15:0] r_len;
  logic       r_full, r_empty, r_req, r_lreq, r_done, r_ovf, r_udf;

  int n_checks = 0;
  int n_pass   = 0;

  i2c_dma_fifo #(.DATA_WIDTH(8), .DEPTH(16), .DIR(1'b0)) dut_tx (
    .i2c_core_clk(clk), .i2c_rst(rst),
    .wr_en_i(t_wr), .wr_data_i(t_wdata), .rd_en_i(t_rd), .rd_data_o(t_rdata),
    .full_o(t_full), .empty_o(t_empty), .level_o(t_level), .flush_i(t_flush),
    .dma_en_i(t_en), .burst_i(t_burst), .xfer_len_i(t_len),
    .dma_req_o(t_req), .dma_lreq_o(t_lreq), .dma_clr_i(t_clr), .dma_tc_i(t_tc),
    .done_o(t_done), .ovf_o(t_ovf), .udf_o(t_udf), .err_clr_i(t_errclr)
  );

  i2c_dma_fifo #(.DATA_WIDTH(8), .DEPTH(16), .DIR(1'b1)) dut_rx (
    .i2c_core_clk(clk), .i2c_rst(rst),
    .wr_en_i(r_wr), .wr_data_i(r_wdata), .rd_en_i(r_rd), .rd_data_o(r_rdata),
    .full_o(r_full), .empty_o(r_empty), .level_o(r_level), .flush_i(r_flush),
    .dma_en_i(r_en), .burst_i(r_burst), .xfer_len_i(r_len),
    .dma_req_o(r_req), .dma_lreq_o(r_lreq), .dma_clr_i(r_clr), .dma_tc_i(r_tc),
    .done_o(r_done), .ovf_o(r_ovf), .udf_o(r_udf), .err_clr_i(r_errclr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {t_wr, t_rd, t_flush, t_en, t_clr, t_tc, t_errclr} = '0;
    {r_wr, r_rd, r_flush, r_en, r_clr, r_tc, r_errclr} = '0;
    t_wdata = '0; r_wdata = '0;
    t_burst = 5'd4; r_burst = 5'd8;
    t_len = '0; r_len = '0;
    step(); step();
    rst = 1'b0;

    check("rst_rdata", t_rdata, 0);
    check("rst_full", t_full, 0);
    check("rst_empty", t_empty, 1);
    check("rst_level", t_level, 0);
    check("rst_req", {t_req, t_lreq, t_done}, 0);
    check("rst_err", {t_ovf, t_udf}, 0);

    // Fill to full, overflow, drain in order
    for (int i = 0; i < 16; i++) begin
      t_wr = 1'b1; t_wdata = 8'(i);
      step();
      if (i == 0) begin
        check("first_push_empty", t_empty, 0);
        check("first_push_data", t_rdata, 8'h00);
      end
    end
    check("fill_full", t_full, 1);
    check("fill_level", t_level, 16);
    t_wdata = 8'hAA;
    step();
    check("ovf_set", t_ovf, 1);
    check("ovf_level", t_level, 16);
    t_wr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("pop_order", t_rdata, 8'(i));
      t_rd = 1'b1;
      step();
    end
    t_rd = 1'b0;
    check("drain_empty", t_empty, 1);
    check("drain_level", t_level, 0);
    t_errclr = 1'b1; step(); t_errclr = 1'b0;
    check("ovf_clr", t_ovf, 0);

    // Wrap: advance pointers, fill, push+pop while full, drain across wrap
    for (int i = 0; i < 10; i++) begin
      t_wr = 1'b1; t_wdata = 8'(i); step(); t_wr = 1'b0;
      t_rd = 1'b1; step(); t_rd = 1'b0;
    end
    for (int k = 0; k < 16; k++) begin
      t_wr = 1'b1; t_wdata = 8'h20 + 8'(k); step();
    end
    check("wrap_full", t_full, 1);
    for (int k = 0; k < 4; k++) begin
      check("full_pp_head", t_rdata, 8'h20 + 8'(k));
      t_wr = 1'b1; t_rd = 1'b1; t_wdata = 8'h30 + 8'(k);
      step();
    end
    check("full_pp_level", t_level, 16);
    check("full_pp_noovf", t_ovf, 0);
    t_wr = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("wrap_order", t_rdata, 8'h24 + 8'(k));
      t_rd = 1'b1;
      step();
    end
    t_rd = 1'b0;
    check("wrap_empty", t_empty, 1);
    t_wr = 1'b1; t_rd = 1'b1; t_wdata = 8'h55;
    step();
    t_wr = 1'b0; t_rd = 1'b0;
    check("empty_pp_udf", t_udf, 1);
    check("empty_pp_level", t_level, 1);
    check("empty_pp_data", t_rdata, 8'h55);
    t_rd = 1'b1; t_errclr = 1'b1; step(); t_rd = 1'b0; t_errclr = 1'b0;
    check("udf_clr", t_udf, 0);
    check("empty_again", t_level, 0);

    // TX DMA: burst 4, length 10
    t_burst = 5'd4; t_len = 16'd10; t_en = 1'b1;
    step(); check("tx_req_e0", t_req, 0);
    step(); check("tx_req_e1", t_req, 0);
    step(); check("tx_req_rise", t_req, 1);
    check("tx_lreq_low", t_lreq, 0);
    for (int k = 0; k < 4; k++) begin
      t_wr = 1'b1; t_wdata = 8'(k); step();
    end
    t_wr = 1'b0;
    check("tx_req_in_burst", t_req, 1);
    t_clr = 1'b1; step(); t_clr = 1'b0;
    check("tx_req_clr0", t_req, 0);
    step(); check("tx_req_clr1", t_req, 0);
    step(); step();
    check("tx_req_again", t_req, 1);
    check("tx_req_again_l", t_lreq, 0);
    for (int k = 0; k < 4; k++) begin
      t_wr = 1'b1; t_wdata = 8'(k + 4); step();
    end
    t_wr = 1'b0;
    t_clr = 1'b1; step(); t_clr = 1'b0;
    check("tx_req_clr2", {t_req, t_lreq}, 0);
    step(); step(); step();
    check("tx_lreq", t_lreq, 1);
    check("tx_lreq_req", t_req, 0);
    for (int k = 0; k < 2; k++) begin
      t_wr = 1'b1; t_wdata = 8'(k + 8); step();
    end
    t_wr = 1'b0;
    t_clr = 1'b1; step(); t_clr = 1'b0;
    check("tx_final_clr", {t_req, t_lreq, t_done}, 0);
    step(); check("tx_done", t_done, 1);
    step(); check("tx_done_once", t_done, 0);
    check("tx_done_reqs", {t_req, t_lreq}, 0);
    check("tx_level", t_level, 10);
    t_en = 1'b0; step();

    // Abort in REQ, then reload on re-enable
    t_len = 16'd20; t_en = 1'b1;
    step(); step(); step();
    check("abort_req", t_req, 1);
    t_en = 1'b0; step();
    check("abort_low", {t_req, t_lreq}, 0);
    check("abort_level", t_level, 10);
    t_len = 16'd3; t_en = 1'b1;
    step(); step(); step();
    check("reload_lreq", {t_req, t_lreq}, 2'b01);
    t_en = 1'b0; step();

    // Flush priority on a level-5 FIFO with ovf pending
    for (int k = 0; k < 7; k++) begin
      t_wr = 1'b1; t_wdata = 8'(k); step();
    end
    t_wr = 1'b0;
    check("pre_flush_ovf", t_ovf, 1);
    for (int k = 0; k < 11; k++) begin
      t_rd = 1'b1; step();
    end
    t_rd = 1'b0;
    check("pre_flush_level", t_level, 5);
    t_flush = 1'b1; t_wr = 1'b1; t_wdata = 8'hEE;
    step();
    t_flush = 1'b0; t_wr = 1'b0;
    check("flush_level", t_level, 0);
    check("flush_empty", t_empty, 1);
    check("flush_keeps_ovf", t_ovf, 1);

    // RX DMA: burst 8, length 3
    r_burst = 5'd8; r_len = 16'd3; r_en = 1'b1;
    step();
    check("rx_idle_reqs", {r_req, r_lreq}, 0);
    for (int k = 0; k < 3; k++) begin
      r_wr = 1'b1; r_wdata = 8'h61 + 8'(k); step();
    end
    r_wr = 1'b0;
    check("rx_pre_lreq", r_lreq, 0);
    step(); check("rx_pre_lreq2", r_lreq, 0);
    step();
    check("rx_lreq", {r_req, r_lreq}, 2'b01);
    for (int k = 0; k < 3; k++) begin
      check("rx_pop_data", r_rdata, 8'h61 + 8'(k));
      r_rd = 1'b1; step();
    end
    r_rd = 1'b0;
    r_tc = 1'b1; step(); r_tc = 1'b0;
    check("rx_done", r_done, 1);
    check("rx_tc_reqs", {r_req, r_lreq}, 0);
    step();
    check("rx_done_once", r_done, 0);
    check("rx_after_reqs", {r_req, r_lreq}, 0);
    check("rx_flags", {r_udf, r_ovf, r_empty}, 3'b001);
    r_en = 1'b0;

    // Reset while in REQ
    t_burst = 5'd4; t_len = 16'd10; t_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      t_wr = (k == 0); t_wdata = 8'h77; step();
    end
    t_wr = 1'b0;
    check("pre_rst_req", t_req, 1);
    rst = 1'b1; step(); rst = 1'b0; t_en = 1'b0;
    check("rst2_reqs", {t_req, t_lreq, t_done}, 0);
    check("rst2_fifo", {t_full, t_empty, t_level}, {2'b01, 5'd0});
    check("rst2_err", {t_ovf, t_udf}, 0);
    check("rst2_rdata", t_rdata, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
